// File: rtl/booth_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_pkg : shared FSM states, default width and round-robin grant helper
// Rev 1.0
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_REQ       = 8;
  localparam int MAX_REQ_W     = 3;

  // One-hot grant of the first set request at or above ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] req,
                                                  input int ptr,
                                                  input int n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && !found) begin
        idx = (ptr + i) % n;
        if (req[idx[MAX_REQ_W-1:0]]) begin
          g[idx[MAX_REQ_W-1:0]] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_seq_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_seq_core : radix-2 Booth iteration datapath, one iteration per clock
// Rev 1.0
// ---------------------------------------------------------------------------
module booth_seq_core
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    q_d   = q_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    run_d = run_q;
    sum   = acc_q;
    if (start) begin
      // Multiplicand kept one bit wider so subtracting -2^(WIDTH-1) cannot overflow.
      a_d   = {a[WIDTH-1], a};
      acc_d = '0;
      q_d   = b;
      q1_d  = 1'b0;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      case ({q_q[0], q1_q})
        2'b01:   sum = acc_q + a_q;
        2'b10:   sum = acc_q - a_q;
        default: sum = acc_q;
      endcase
      acc_d = {sum[WIDTH], sum[WIDTH:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
      q1_d  = q_q[0];
      cnt_d = cnt_q - CW'(1);
      run_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done    = run_q && (cnt_q == CW'(1));
  assign product = {acc_q[WIDTH-1:0], q_q};

endmodule
`default_nettype wire

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_mul_arbiter : round-robin sharing of one sequential Booth multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       busy
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] grant_ext;
  logic [ID_W-1:0]    sel;
  logic               accept;
  logic               core_done;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;

  assign req_ext   = MAX_REQ'(req_valid);
  assign grant_ext = rr_grant(req_ext, int'(ptr_q), NUM_REQ);
  assign accept    = (state_q == ST_IDLE) && (|grant_ext);
  assign req_ready = (state_q == ST_IDLE) ? grant_ext[NUM_REQ-1:0] : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_ext[i]) sel = ID_W'(i);
    end
  end

  assign a_sel = req_a[int'(sel)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(sel)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = sel;
          ptr_d   = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
          state_d = ST_CALC;
        end
      end
      ST_CALC: if (core_done) state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  booth_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .a       (a_sel),
    .b       (b_sel),
    .done    (core_done),
    .product (rsp_product)
  );

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_booth_mul_arbiter : directed stimulus with queue scoreboard and monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_booth_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [2*WIDTH-1:0]       rsp_product;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  typedef struct {
    logic [2*WIDTH-1:0] p;
    logic [ID_W-1:0]    id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  booth_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic [1:0] id);
    exp_t e;
    e.p  = p;
    e.id = id;
    sb.push_back(e);
  endtask

  // Monitor: every accepted response is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {24'd0, rsp_product}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_product", {24'd0, rsp_product}, {24'd0, e.p});
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input bit chk_rdy, input logic [3:0] exp_rdy);
    int n;
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_valid[idx] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[idx]) chk("grant_timeout", 32'd0, 32'd1);
    if (chk_rdy) chk("req_ready_onehot", {28'd0, req_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    int k;
    int cnt_v;
    logic [1:0] ord [5];
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_product", {24'd0, rsp_product}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2, with latency measurement.
    issue(2, 4'd3, 4'hE, 1'b1, 4'b0100);
    push(8'hFA, 2'd2);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 32'd5);
    wait_idle();

    // Extreme operands.
    issue(1, 4'h8, 4'h8, 1'b0, 4'b0000);
    push(8'h40, 2'd1);
    wait_idle();
    issue(0, 4'h8, 4'h7, 1'b0, 4'b0000);
    push(8'hC8, 2'd0);
    wait_idle();
    issue(3, 4'h7, 4'h7, 1'b0, 4'b0000);
    push(8'h31, 2'd3);
    wait_idle();

    // All requesters continuously valid: strict round-robin.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 4'(i + 1);
      req_b[i*WIDTH +: WIDTH] = 4'hF;
    end
    push(8'hFF, 2'd0);
    push(8'hFE, 2'd1);
    push(8'hFD, 2'd2);
    push(8'hFC, 2'd3);
    push(8'hFF, 2'd0);
    req_valid = 4'b1111;
    k = 0;
    n = 0;
    while (k < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ready != 4'b0000) begin
        chk("rr_order", {28'd0, req_ready}, 32'd1 << ord[k]);
        k++;
        if (k == 5) begin
          @(posedge clk);
          #1;
          req_valid = '0;
        end
      end
    end
    if (k != 5) chk("rr_grants", k, 32'd5);
    req_valid = '0;
    wait_idle();

    // Backpressure in DONE while another request waits.
    rsp_ready = 1'b0;
    issue(1, 4'd5, 4'd3, 1'b0, 4'b0000);
    push(8'h0F, 2'd1);
    req_a[3*WIDTH +: WIDTH] = 4'hD;
    req_b[3*WIDTH +: WIDTH] = 4'd2;
    req_valid[3] = 1'b1;
    push(8'hFA, 2'd3);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_product", {24'd0, rsp_product}, 32'h0F);
      chk("bp_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_next_grant", {28'd0, req_ready}, 32'b1000);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_idle();

    // Asynchronous reset during the second CALC cycle.
    issue(2, 4'd6, 4'd5, 1'b0, 4'b0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_product", {24'd0, rsp_product}, 32'd0);
    chk("arst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_v = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt_v++;
    end
    chk("arst_no_rsp", cnt_v, 32'd0);
    // Pointer back at 0: from {1,3} requester 1 wins; dropping before the edge grants nothing.
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("arst_ptr_grant", {28'd0, req_ready}, 32'b0010);
    req_valid = '0;
    @(posedge clk);
    #1;
    chk("drop_no_effect_busy", {31'd0, busy}, 32'd0);

    // Operands change right after accept.
    issue(0, 4'd2, 4'd3, 1'b0, 4'b0000);
    push(8'h06, 2'd0);
    req_a[0 +: WIDTH] = 4'd7;
    req_b[0 +: WIDTH] = 4'd7;
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Shares one sequential radix-2 Booth multiplier among NUM_REQ requesters using round-robin arbitration.
- Each requester presents a signed operand pair with a valid/ready handshake.
- The block grants one requester, runs WIDTH Booth iterations (one per clock), then returns the signed 2*WIDTH-bit product tagged with the requester ID.
- Sits between the multiply clients and the shared arithmetic resource.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, signed operand width in bits (2..16); product width is 2*WIDTH
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, at most one bit high
req_a  input  NUM_REQ*WIDTH  packed signed multiplicands; requester i uses bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  packed signed multipliers, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_product  output  2*WIDTH  signed product A*B
rsp_id  output  ID_W  index of the requester that owns rsp_product
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n=0), all outputs and state cleared:
  - req_ready=0, rsp_valid=0, rsp_product=0, rsp_id=0, busy=0.
  - FSM=IDLE, round-robin pointer=0, iteration counter=0.
  - Reset mid-CALC or mid-DONE discards the operation; no response is ever produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid=1, searching from pointer upward with wrap-around (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - If no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
  - On the edge where req_valid[g]&req_ready[g]:
    - Latch A=req_a[g] and B=req_b[g].
    - Latch rsp_id=g.
    - Set pointer=(g+1) mod NUM_REQ.
    - Clear the accumulator, set Q_1=0, load counter=WIDTH.
    - Go to CALC.
- CALC:
  - req_ready=0 for all requesters.
  - Each cycle, on {Q[0],Q_1}:
    - 01: acc += A.
    - 10: acc -= A.
    - 00/11: no add.
  - Then arithmetic-shift right the {acc,Q,Q_1} combination by one, preserving acc's sign bit, and decrement the counter.
  - Add/subtract is performed at WIDTH+1 bits so that A=-2^(WIDTH-1) does not overflow.
  - After WIDTH iterations (counter reaches 0), go to DONE.
- DONE:
  - rsp_valid=1; rsp_product={acc[WIDTH-1:0],Q} as a signed 2*WIDTH-bit value.
  - rsp_product and rsp_id are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready, go to IDLE and clear rsp_valid the next cycle.
- Latency: accept edge -> rsp_valid high after exactly WIDTH+1 clock edges. Minimum back-to-back issue interval is WIDTH+2 cycles.
- Arithmetic: product equals the exact two's-complement A*B for all operand pairs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
- Boundary conditions:
  - req_valid dropping before a grant is legal and has no effect.
  - Operands are only sampled on the accept edge; changes afterwards are ignored.
  - Requests arriving while busy wait; they are never lost provided req_valid is held.
  - Simultaneous requests are served strictly round-robin: no requester waits more than NUM_REQ-1 grants.
  - Pointer wraps from NUM_REQ-1 to 0.
  - rsp_ready held high early has no effect before DONE.

Decomposition:
- Shared package booth_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - localparam for the default WIDTH;
  - a function computing round-robin one-hot grant from a request vector and pointer.
- Natural sub-module: booth_seq_core.
  - Contains the accumulator/Q/Q_1/counter iteration datapath.
  - Interface: start, a, b in; done, product out.
  - The arbiter top keeps the FSM, pointer, ID and handshakes.

Test Plan:
- Single request, requester 2, A=3, B=-2 -> req_ready=4'b0100 that cycle; rsp_valid after 5 edges; rsp_product=8'hFA (-6); rsp_id=2.
- Extreme operands, A=-8, B=-8 -> rsp_product=8'h40 (+64); A=-8, B=7 -> 8'hC8 (-56); A=7, B=7 -> 8'h31 (+49).
- All four requesters valid continuously after reset, requester i using A=i+1, B=-1 -> grant order 0,1,2,3,0; products -1,-2,-3,-4,-1 with matching rsp_id.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE with A=5, B=3 -> rsp_valid, rsp_product=8'h0F and rsp_id stay stable; req_ready stays 0; completes on the first cycle rsp_ready=1.
- Assert rst_n=0 asynchronously during the 2nd CALC cycle of A=6, B=5 -> all outputs 0 immediately; after release no rsp_valid appears; pointer restarts at requester 0.
- Change req_a/req_b the cycle after accept (A=2, B=3 accepted, then driven to 7, 7) -> rsp_product=8'h06.
